fnmadd_addend_align: RTL and testbench
======================================

# fnmadd_addend_align

Two-stage pipelined addend alignment stage for the fused negative multiply-add datapath, sitting directly downstream of exponent comparison. Consumes the shift amount, result exponent and small-exponent flag produced there, together with C's fraction and subnormal flag. Places C's significand at the top of the wide adder field, right-shifts it by `shamt`, and collects every bit shifted out into a sticky bit. It optionally one's-complements the result for effective subtraction and hands the aligned addend to the three-operand adder stage over a valid/ready handshake.

## Interface
- `EXP_WIDTH`, 8: exponent width (11 for double).
- `SIG_WIDTH`, 23: stored fraction width (52 for double).
- `SHAMT_WIDTH`, 6: shift-amount width; fixed, matches exponent comparison.
- `ADD_WIDTH`, 3*(SIG_WIDTH+1)+3: adder field width (75 single, 162 double).
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `flush` in 1: synchronous pipeline kill.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: stage accepts a beat.
- `c_frac` in SIG_WIDTH: C stored fraction.
- `c_is_subnormal` in 1: hidden bit is 0 when set.
- `shamt` in SHAMT_WIDTH: right-shift amount, already subnormal-adjusted upstream.
- `res_exp` in EXP_WIDTH: sideband, passed through unchanged.
- `c_exp_is_small` in 1: sideband, passed through unchanged.
- `eff_sub` in 1: effective subtraction request.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: downstream accepts.
- `addend` out ADD_WIDTH: aligned, conditionally complemented addend.
- `sticky` out 1: OR of all bits shifted below bit 0.
- `cin` out 1: carry-in for the two's-complement completion; equals the beat's `eff_sub`.
- `out_res_exp` out EXP_WIDTH; `out_c_exp_is_small` out 1: sideband.

## Operation
- Significand: sig = {~c_is_subnormal, c_frac}, SIG_WIDTH+1 bits, placed at bits [ADD_WIDTH-1 : ADD_WIDTH-SIG_WIDTH-1] of an extended field with SIG_WIDTH+1 guard positions below bit 0.
- Stage 1 (coarse): shifts right by shamt[5:3]*8. Registers the partial field, the partial sticky (OR of positions already below the guard region, if any), shamt[2:0], and the sideband.
- Stage 2 (fine): shifts right by shamt[2:0]. sticky = partial sticky OR all guard positions. addend = eff_sub ? ~field[ADD_WIDTH-1:0] : field[ADD_WIDTH-1:0]. Registers the outputs.
- Sticky is computed from the uncomplemented magnitude, never from the complemented value.
- shamt = 0 gives no shift. shamt = 63 is the maximum; there is no saturation logic beyond the input width.
- Handshake: a transfer occurs when valid && ready on the same edge. Each stage register loads when it is empty or its consumer takes the beat. in_ready = !s1_valid || s2_can_load. s2_can_load = !s2_valid || out_ready.
- Outputs are held stable while out_valid && !out_ready. Full throughput is one beat per cycle with no bubbles.
- flush: clears s1_valid and s2_valid on the next edge. A beat presented on the flush cycle is dropped. Flush has priority over load. Data registers are don't-care.

## Timing
- Latency: 2 cycles from accepted input to out_valid when there is no backpressure.
- Reset (async assert, sync release): s1_valid = s2_valid = 0, out_valid = 0, addend = 0, sticky = 0, cin = 0, out_res_exp = 0, out_c_exp_is_small = 0, in_ready = 1.
- Reset asserted mid-flight discards all beats. No output transfer occurs in the reset cycle.
- Simultaneous out_ready and in_valid with both stages full: all stages advance and one beat enters.
- out_ready low with both stages full: in_ready = 0, combinationally, in the same cycle.

## Structure
- Shared package `fp_fma_pkg`:
  - format constants: EXP_WIDTH, SIG_WIDTH, BIAS, SHAMT_WIDTH, ADD_WIDTH for single/double;
  - a struct for the sideband (res_exp, c_exp_is_small, eff_sub).
- Sub-module `shift_right_sticky` (parameterized width, shift width, stride): one shift level plus sticky OR. Instantiated once per stage.

## Test plan
- Single precision, c_frac = 0, normal, shamt = 0, eff_sub = 0 → after 2 cycles: addend = 1<<74, sticky = 0, cin = 0.
- c_frac = 0x000FFF, normal, shamt = 63 → addend = 0x800, sticky = 1.
- Subnormal, c_frac = 0x000001, shamt = 9, eff_sub = 1 → addend = ~(1<<42) (75 bits), sticky = 0, cin = 1.
- Back-to-back beats at shamt 0..63 with out_ready toggling at random → every beat is delivered in order, exactly once, matching the reference model, with outputs stable during stalls.
- Both stages full, out_ready = 0 → in_ready = 0. Assert flush → out_valid = 0 and in_ready = 1 next cycle; the held beats are never emitted.
- Drop rst_n with 2 beats in flight → outputs go to zero immediately. After release the first new beat appears exactly 2 cycles after acceptance.

Source files
------------

// File: rtl/fp_fma_pkg.sv
// fp_fma_pkg: shared format constants and sideband type for the fused multiply-add datapath (rev 1.0)
`default_nettype none

package fp_fma_pkg;

  localparam int SP_EXP_WIDTH   = 8;
  localparam int SP_SIG_WIDTH   = 23;
  localparam int SP_BIAS        = 127;
  localparam int SP_SHAMT_WIDTH = 6;
  localparam int SP_ADD_WIDTH   = 3 * (SP_SIG_WIDTH + 1) + 3;

  localparam int DP_EXP_WIDTH   = 11;
  localparam int DP_SIG_WIDTH   = 52;
  localparam int DP_BIAS        = 1023;
  localparam int DP_SHAMT_WIDTH = 6;
  localparam int DP_ADD_WIDTH   = 3 * (DP_SIG_WIDTH + 1) + 3;

  // Sized for the widest supported format; narrower formats zero-extend.
  localparam int SIDE_EXP_WIDTH = DP_EXP_WIDTH;

  typedef struct packed {
    logic [SIDE_EXP_WIDTH-1:0] res_exp;
    logic                      c_exp_is_small;
    logic                      eff_sub;
  } sideband_t;

endpackage

`default_nettype wire

// File: rtl/shift_right_sticky.sv
// shift_right_sticky: one right-shift level by amount*STRIDE with OR of all bits shifted out (rev 1.0)
`default_nettype none

module shift_right_sticky #(
  parameter int WIDTH       = 8,
  parameter int SHIFT_WIDTH = 3,
  parameter int STRIDE      = 1
) (
  input  logic [WIDTH-1:0]       data_in,
  input  logic [SHIFT_WIDTH-1:0] amount,
  output logic [WIDTH-1:0]       data_out,
  output logic                   sticky
);

  logic [31:0]      distance;
  logic [WIDTH-1:0] lost_mask;

  assign distance  = 32'(amount) * 32'(STRIDE);
  assign data_out  = data_in >> distance;
  assign lost_mask = ~({WIDTH{1'b1}} << distance);
  assign sticky    = |(data_in & lost_mask);

endmodule

`default_nettype wire

// File: rtl/fnmadd_addend_align.sv
// fnmadd_addend_align: two-stage addend alignment (coarse/fine shift, sticky, optional complement) (rev 1.0)
`default_nettype none

module fnmadd_addend_align
  import fp_fma_pkg::*;
#(
  parameter int EXP_WIDTH   = SP_EXP_WIDTH,
  parameter int SIG_WIDTH   = SP_SIG_WIDTH,
  parameter int SHAMT_WIDTH = SP_SHAMT_WIDTH,
  parameter int ADD_WIDTH   = 3 * (SIG_WIDTH + 1) + 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SIG_WIDTH-1:0]   c_frac,
  input  logic                   c_is_subnormal,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  input  logic [EXP_WIDTH-1:0]   res_exp,
  input  logic                   c_exp_is_small,
  input  logic                   eff_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADD_WIDTH-1:0]   addend,
  output logic                   sticky,
  output logic                   cin,
  output logic [EXP_WIDTH-1:0]   out_res_exp,
  output logic                   out_c_exp_is_small
);

  localparam int SIGW     = SIG_WIDTH + 1;
  localparam int GUARD    = SIGW;
  localparam int EXT      = ADD_WIDTH + GUARD;
  localparam int COARSE_W = SHAMT_WIDTH - 3;

  logic [SIGW-1:0] sig;
  logic [EXT-1:0]  field_in;
  logic [EXT-1:0]  coarse_out;
  logic            coarse_sticky;
  sideband_t       side_in;

  logic            s1_valid;
  logic [EXT-1:0]  s1_field;
  logic            s1_sticky;
  logic [2:0]      s1_fine;
  sideband_t       s1_side;

  logic [EXT-1:0]       fine_out;
  logic                 fine_sticky;
  logic                 sticky_next;
  logic [ADD_WIDTH-1:0] addend_next;

  logic s2_valid;
  logic s2_can_load;
  logic unused_side_exp;

  // Significand sits at the top of the adder field; GUARD extra positions catch bits below bit 0.
  assign sig      = {~c_is_subnormal, c_frac};
  assign field_in = {sig, {ADD_WIDTH{1'b0}}};
  assign side_in  = '{res_exp:        SIDE_EXP_WIDTH'(res_exp),
                      c_exp_is_small: c_exp_is_small,
                      eff_sub:        eff_sub};

  shift_right_sticky #(
    .WIDTH      (EXT),
    .SHIFT_WIDTH(COARSE_W),
    .STRIDE     (8)
  ) u_coarse (
    .data_in (field_in),
    .amount  (shamt[SHAMT_WIDTH-1:3]),
    .data_out(coarse_out),
    .sticky  (coarse_sticky)
  );

  assign s2_can_load = !s2_valid || out_ready;
  assign in_ready    = !s1_valid || s2_can_load;
  assign out_valid   = s2_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_field  <= '0;
      s1_sticky <= 1'b0;
      s1_fine   <= '0;
      s1_side   <= '0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (in_ready && in_valid) begin
        s1_field  <= coarse_out;
        s1_sticky <= coarse_sticky;
        s1_fine   <= shamt[2:0];
        s1_side   <= side_in;
      end
    end
  end

  shift_right_sticky #(
    .WIDTH      (EXT),
    .SHIFT_WIDTH(3),
    .STRIDE     (1)
  ) u_fine (
    .data_in (s1_field),
    .amount  (s1_fine),
    .data_out(fine_out),
    .sticky  (fine_sticky)
  );

  // Sticky comes from the magnitude before any complement is applied.
  assign sticky_next = s1_sticky | fine_sticky | (|fine_out[GUARD-1:0]);
  assign addend_next = fine_out[EXT-1:GUARD] ^ {ADD_WIDTH{s1_side.eff_sub}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid           <= 1'b0;
      addend             <= '0;
      sticky             <= 1'b0;
      cin                <= 1'b0;
      out_res_exp        <= '0;
      out_c_exp_is_small <= 1'b0;
    end else begin
      if (flush) begin
        s2_valid <= 1'b0;
      end else if (s2_can_load) begin
        s2_valid <= s1_valid;
      end
      if (s2_can_load && s1_valid) begin
        addend             <= addend_next;
        sticky             <= sticky_next;
        cin                <= s1_side.eff_sub;
        out_res_exp        <= EXP_WIDTH'(s1_side.res_exp);
        out_c_exp_is_small <= s1_side.c_exp_is_small;
      end
    end
  end

  assign unused_side_exp = ^s1_side.res_exp;

endmodule

`default_nettype wire

// File: tb/tb_fnmadd_addend_align.sv
// tb_fnmadd_addend_align: randomized scoreboard bench for the addend alignment stage (rev 1.0)
`default_nettype none

module tb_fnmadd_addend_align;

  localparam int EW = 8;
  localparam int SW = 23;
  localparam int AW = 3 * (SW + 1) + 3;
  localparam int TOP = AW - SW - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [SW-1:0] c_frac = '0;
  logic          c_is_subnormal = 1'b0;
  logic [5:0]    shamt = '0;
  logic [EW-1:0] res_exp = '0;
  logic          c_exp_is_small = 1'b0;
  logic          eff_sub = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] addend;
  logic          sticky;
  logic          cin;
  logic [EW-1:0] out_res_exp;
  logic          out_c_exp_is_small;

  typedef struct packed {
    logic [AW-1:0] addend;
    logic          sticky;
    logic          cin;
    logic [EW-1:0] res_exp;
    logic          c_small;
  } resp_t;

  resp_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    ready_mode = 0;

  fnmadd_addend_align #(
    .EXP_WIDTH  (EW),
    .SIG_WIDTH  (SW),
    .SHAMT_WIDTH(6),
    .ADD_WIDTH  (AW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flush             (flush),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .c_frac            (c_frac),
    .c_is_subnormal    (c_is_subnormal),
    .shamt             (shamt),
    .res_exp           (res_exp),
    .c_exp_is_small    (c_exp_is_small),
    .eff_sub           (eff_sub),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .addend            (addend),
    .sticky            (sticky),
    .cin               (cin),
    .out_res_exp       (out_res_exp),
    .out_c_exp_is_small(out_c_exp_is_small)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Reference: significand scaled to the top of the field, divided by 2^shamt; lost low bits form sticky.
  function automatic resp_t model(input logic [SW-1:0] f, input logic sub, input logic [5:0] sh,
                                  input logic [EW-1:0] e, input logic sm, input logic eff);
    resp_t       r;
    logic [SW:0] sig;
    logic [SW:0] low;
    logic [AW-1:0] mag;
    int          lost;
    sig  = {~sub, f};
    mag  = (AW'(sig) << TOP) >> sh;
    lost = int'(sh) - TOP;
    low  = '0;
    if (lost > 0) low = sig << ((SW + 1) - lost);
    r.addend  = eff ? ~mag : mag;
    r.sticky  = (low != '0);
    r.cin     = eff;
    r.res_exp = e;
    r.c_small = sm;
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic send(input logic [SW-1:0] f, input logic sub, input logic [5:0] sh,
                      input logic [EW-1:0] e, input logic sm, input logic eff,
                      input logic use_model, input resp_t fixed);
    int n = 0;
    @(negedge clk);
    c_frac = f; c_is_subnormal = sub; shamt = sh;
    res_exp = e; c_exp_is_small = sm; eff_sub = eff;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=in_ready 0 required=in_ready 1");
    end else begin
      exp_q.push_back(use_model ? model(f, sub, sh, e, sm, eff) : fixed);
    end
    @(posedge clk);
  endtask

  task automatic send_random();
    send(SW'($urandom()), ($urandom_range(0, 7) == 0), 6'($urandom_range(0, 63)),
         EW'($urandom()), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, '0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, 128'(exp_q.size()), 128'(0));
  endtask

  task automatic latency_check(input string name);
    @(negedge clk);
    in_valid = 1'b0;
    #3;
    check({name, "_cycle1"}, 128'(out_valid), 128'(0));
    @(negedge clk);
    #3;
    check({name, "_cycle2"}, 128'(out_valid), 128'(1));
  endtask

  // Monitor: pops on every output transfer and verifies outputs are frozen across stalls.
  resp_t held_val;
  logic  held = 1'b0;
  logic  flush_d = 1'b0;
  always @(negedge clk) begin
    resp_t cur;
    resp_t e;
    #2;
    if (!rst_n) begin
      held    = 1'b0;
      flush_d = 1'b0;
    end else begin
      cur = '{addend: addend, sticky: sticky, cin: cin, res_exp: out_res_exp, c_small: out_c_exp_is_small};
      if (held && !flush_d) check("stall_hold", {out_valid, cur}, {1'b1, held_val});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%0h required=no beat", cur);
        end else begin
          e = exp_q.pop_front();
          check("beat", 128'(cur), 128'(e));
        end
      end
      held     = out_valid && !out_ready;
      held_val = cur;
      flush_d  = flush;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    resp_t fx;
    ready_mode = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_addend", 128'(addend), 128'(0));
    check("rst_sticky", 128'(sticky), 128'(0));
    check("rst_cin", 128'(cin), 128'(0));
    check("rst_res_exp", 128'(out_res_exp), 128'(0));
    check("rst_small", 128'(out_c_exp_is_small), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    rst_n = 1'b1;

    fx = '{addend: AW'(1) << 74, sticky: 1'b0, cin: 1'b0, res_exp: 8'h7f, c_small: 1'b0};
    send(23'h000000, 1'b0, 6'd0, 8'h7f, 1'b0, 1'b0, 1'b0, fx);
    latency_check("latency");

    fx = '{addend: AW'(12'h800), sticky: 1'b1, cin: 1'b0, res_exp: 8'h95, c_small: 1'b1};
    send(23'h000FFF, 1'b0, 6'd63, 8'h95, 1'b1, 1'b0, 1'b0, fx);
    fx = '{addend: ~(AW'(1) << 42), sticky: 1'b0, cin: 1'b1, res_exp: 8'h01, c_small: 1'b0};
    send(23'h000001, 1'b1, 6'd9, 8'h01, 1'b0, 1'b1, 1'b0, fx);
    idle(4);
    drain("directed_drain");

    ready_mode = 1;
    for (int i = 0; i < 64; i++) begin
      send(SW'($urandom()), ($urandom_range(0, 7) == 0), 6'(i), EW'($urandom()),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, '0);
    end
    for (int i = 0; i < 300; i++) send_random();
    idle(1);
    ready_mode = 0;
    drain("random_drain");

    idle(2);
    ready_mode = 2;
    send_random();
    send_random();
    @(negedge clk);
    in_valid = 1'b1;
    #1;
    check("full_in_ready", 128'(in_ready), 128'(0));
    check("full_out_valid", 128'(out_valid), 128'(1));
    @(negedge clk);
    flush = 1'b1;
    exp_q.delete();
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    #3;
    check("flush_out_valid", 128'(out_valid), 128'(0));
    check("flush_in_ready", 128'(in_ready), 128'(1));
    ready_mode = 0;
    idle(6);

    ready_mode = 2;
    send_random();
    send_random();
    @(negedge clk);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_addend", 128'(addend), 128'(0));
    check("midrst_sticky", 128'(sticky), 128'(0));
    check("midrst_cin", 128'(cin), 128'(0));
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    exp_q.delete();
    ready_mode = 0;
    idle(2);
    rst_n = 1'b1;
    send_random();
    latency_check("post_rst_latency");
    idle(4);
    drain("final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
